// File: rtl/prio_encoder_q.sv
// Registered priority encoder: sticky-latches request lines and emits one pending index
// per valid/ready transfer, using either fixed (lowest-first) or round-robin selection.
module prio_encoder_q #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_in,
    input  logic         mode,
    output logic [W-1:0] code_out,
    output logic         code_valid,
    input  logic         code_ready,
    output logic [N-1:0] pending_out,
    output logic         ovf,
    input  logic         clr_ovf
);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] code_q, code_d;
    logic         valid_q, valid_d;
    logic [W-1:0] rr_ptr_q, rr_ptr_d;
    logic         ovf_q, ovf_d;

    logic [W-1:0] start;
    logic [W-1:0] cand;
    logic [W-1:0] sel;
    logic         found;
    logic         load;
    logic [N-1:0] clear_vec;
    int unsigned  idx;

    // Scan the registered pending vector from the start point, wrapping N-1 -> 0.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        start = mode ? rr_ptr_q : '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(start) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            cand = idx[W-1:0];
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign load = found && (!valid_q || code_ready);

    always_comb begin
        clear_vec = '0;
        if (load) begin
            clear_vec[sel] = 1'b1;
        end
    end

    // A request landing on a bit cleared this cycle simply re-arms it; only a
    // request on a bit that stays pending counts as an overflow.
    always_comb begin
        pending_d = (pending_q & ~clear_vec) | req_in;
        ovf_d     = ovf_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (|(req_in & pending_q & ~clear_vec)) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        code_d   = code_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            code_d   = sel;
            valid_d  = 1'b1;
            rr_ptr_d = (sel == W'(N - 1)) ? '0 : sel + W'(1);
        end else if (valid_q && code_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            rr_ptr_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            rr_ptr_q  <= rr_ptr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign code_out    = code_q;
    assign code_valid  = valid_q;
    assign pending_out = pending_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Self-checking bench for prio_encoder_q: an N=8 instance for most scenarios and an
// N=6 instance for round-robin wrap-around on a non-power-of-two width.
module tb_prio_encoder_q;

    logic       clk;
    logic       rst;
    logic       mode;
    logic       clr_ovf;

    logic [7:0] req8;
    logic [2:0] code8;
    logic       valid8;
    logic       ready8;
    logic [7:0] pending8;
    logic       ovf8;

    logic [5:0] req6;
    logic [2:0] code6;
    logic       valid6;
    logic       ready6;
    logic [5:0] pending6;
    logic       ovf6;

    int checks;
    int errors;
    int exp_q[$];

    prio_encoder_q #(.N(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req8),
        .mode       (mode),
        .code_out   (code8),
        .code_valid (valid8),
        .code_ready (ready8),
        .pending_out(pending8),
        .ovf        (ovf8),
        .clr_ovf    (clr_ovf)
    );

    prio_encoder_q #(.N(6)) dut6 (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req6),
        .mode       (mode),
        .code_out   (code6),
        .code_valid (valid6),
        .code_ready (ready6),
        .pending_out(pending6),
        .ovf        (ovf6),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req8    = '0;
        req6    = '0;
        ready8  = 1'b0;
        ready6  = 1'b0;
        mode    = 1'b0;
        clr_ovf = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        exp_q.delete();
    endtask

    task automatic test_reset();
        int valid_seen;
        do_reset();
        mode   = 1'b0;
        ready8 = 1'b0;
        req8   = 8'hA5;
        tick();
        tick();
        req8 = '0;
        checks++;
        if (pending8 !== 8'hA5 || valid8 !== 1'b1) begin
            $display("FAIL reset_setup: pending=%h valid=%b expected pending=a5 valid=1",
                     pending8, valid8);
            errors++;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (code8 !== 3'd0 || valid8 !== 1'b0 || pending8 !== 8'h00 || ovf8 !== 1'b0) begin
            $display("FAIL async_reset: code=%0d valid=%b pending=%h ovf=%b expected all 0",
                     code8, valid8, pending8, ovf8);
            errors++;
        end
        #1 rst = 1'b0;
        valid_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (valid8 !== 1'b0) valid_seen++;
        end
        checks++;
        if (valid_seen != 0) begin
            $display("FAIL idle_after_reset: valid high on %0d cycles expected 0", valid_seen);
            errors++;
        end
    endtask

    task automatic test_fixed_stall();
        int budget;
        do_reset();
        mode   = 1'b0;
        ready8 = 1'b0;
        req8   = 8'b1001_0100;
        exp_q.push_back(2);
        exp_q.push_back(4);
        exp_q.push_back(7);
        tick();
        req8 = '0;
        checks++;
        if (valid8 !== 1'b0 || pending8 !== 8'h94) begin
            $display("FAIL fixed_latency: valid=%b pending=%h expected valid=0 pending=94",
                     valid8, pending8);
            errors++;
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (valid8 !== 1'b1 || code8 !== 3'd2) begin
                $display("FAIL fixed_stall_hold: valid=%b code=%0d expected valid=1 code=2",
                         valid8, code8);
                errors++;
            end
            tick();
        end
        ready8 = 1'b1;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            if (valid8 && ready8) begin
                checks++;
                if (int'(code8) !== exp_q[0]) begin
                    $display("FAIL fixed_order: code=%0d expected %0d", code8, exp_q[0]);
                    errors++;
                end
                void'(exp_q.pop_front());
            end
            tick();
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL fixed_timeout: %0d grants missing expected 0", exp_q.size());
            errors++;
            exp_q.delete();
        end
        checks++;
        if (pending8 !== 8'h00 || valid8 !== 1'b0) begin
            $display("FAIL fixed_drained: pending=%h valid=%b expected pending=00 valid=0",
                     pending8, valid8);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mode   = 1'b1;
        ready8 = 1'b1;
        req8   = 8'b0000_0111;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(0);
            exp_q.push_back(1);
            exp_q.push_back(2);
        end
        tick();
        checks++;
        if (ovf8 !== 1'b0 || pending8 !== 8'h07) begin
            $display("FAIL rr_first_latch: ovf=%b pending=%h expected ovf=0 pending=07",
                     ovf8, pending8);
            errors++;
        end
        tick();
        // With ready held high every cycle must carry a grant.
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (valid8 !== 1'b1) begin
                $display("FAIL rr_bubble: valid=%b at grant %0d expected 1", valid8, i);
                errors++;
            end else if (int'(code8) !== exp_q[0]) begin
                $display("FAIL rr_order: code=%0d at grant %0d expected %0d",
                         code8, i, exp_q[0]);
                errors++;
            end
            void'(exp_q.pop_front());
            tick();
        end
        checks++;
        if (ovf8 !== 1'b1) begin
            $display("FAIL rr_ovf: ovf=%b expected 1", ovf8);
            errors++;
        end
        req8 = '0;
    endtask

    task automatic test_wrap_n6();
        int budget;
        do_reset();
        mode   = 1'b1;
        ready6 = 1'b1;
        req6   = 6'b01_0000;
        exp_q.push_back(4);
        exp_q.push_back(5);
        exp_q.push_back(0);
        tick();
        req6 = 6'b10_0001;
        tick();
        req6 = '0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            if (valid6 && ready6) begin
                checks++;
                if (int'(code6) !== exp_q[0]) begin
                    $display("FAIL wrap_order: code=%0d expected %0d", code6, exp_q[0]);
                    errors++;
                end
                void'(exp_q.pop_front());
            end
            tick();
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL wrap_timeout: %0d grants missing expected 0", exp_q.size());
            errors++;
            exp_q.delete();
        end
        checks++;
        if (pending6 !== 6'h00 || ovf6 !== 1'b0) begin
            $display("FAIL wrap_drained: pending=%h ovf=%b expected pending=00 ovf=0",
                     pending6, ovf6);
            errors++;
        end
    endtask

    task automatic test_rerequest();
        int budget;
        do_reset();
        mode   = 1'b0;
        ready8 = 1'b1;
        req8   = 8'h08;
        exp_q.push_back(3);
        exp_q.push_back(3);
        tick();
        // Index 3 is granted on the coming edge while being requested again.
        req8 = 8'h08;
        tick();
        req8 = '0;
        checks++;
        if (pending8 !== 8'h08 || ovf8 !== 1'b0) begin
            $display("FAIL rereq_keep: pending=%h ovf=%b expected pending=08 ovf=0",
                     pending8, ovf8);
            errors++;
        end
        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            if (valid8 && ready8) begin
                checks++;
                if (int'(code8) !== exp_q[0]) begin
                    $display("FAIL rereq_order: code=%0d expected %0d", code8, exp_q[0]);
                    errors++;
                end
                void'(exp_q.pop_front());
            end
            tick();
            budget++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL rereq_timeout: %0d grants missing expected 0", exp_q.size());
            errors++;
            exp_q.delete();
        end
        checks++;
        if (pending8 !== 8'h00 || ovf8 !== 1'b0) begin
            $display("FAIL rereq_end: pending=%h ovf=%b expected pending=00 ovf=0",
                     pending8, ovf8);
            errors++;
        end
    endtask

    task automatic test_ovf_collision();
        do_reset();
        mode   = 1'b0;
        ready8 = 1'b0;
        req8   = 8'h03;
        tick();
        checks++;
        if (ovf8 !== 1'b0) begin
            $display("FAIL ovf_pre: ovf=%b expected 0", ovf8);
            errors++;
        end
        // Bit 0 is cleared by this edge's load, bit 1 stays pending and overflows.
        req8    = 8'h02;
        clr_ovf = 1'b1;
        tick();
        req8 = '0;
        checks++;
        if (ovf8 !== 1'b1) begin
            $display("FAIL ovf_set_wins: ovf=%b expected 1", ovf8);
            errors++;
        end
        checks++;
        if (valid8 !== 1'b1 || code8 !== 3'd0 || pending8 !== 8'h02) begin
            $display("FAIL ovf_grant: valid=%b code=%0d pending=%h expected 1 0 02",
                     valid8, code8, pending8);
            errors++;
        end
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (ovf8 !== 1'b0) begin
            $display("FAIL ovf_clear: ovf=%b expected 0", ovf8);
            errors++;
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        req8    = '0;
        req6    = '0;
        ready8  = 1'b0;
        ready6  = 1'b0;
        mode    = 1'b0;
        clr_ovf = 1'b0;
        tick();
        test_reset();
        test_fixed_stall();
        test_back_to_back();
        test_wrap_n6();
        test_rerequest();
        test_ovf_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
